// File: rtl/spi_dac_pkg.sv
// Shared types for the SPI DAC stream master: FSM state encoding and channel-width helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package spi_dac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // Width of a channel index; a single-channel build still carries a 1-bit field.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Half-period tick generator: one-cycle tick_o every HALF_DIV clk cycles, reloaded by restart_i.
// Latency: first tick HALF_DIV cycles after the restart cycle.
// Backpressure: none; free-running.
// Ports: clk, rst (async active-high), restart_i (reload counter), tick_o (half-period boundary).
module spi_half_tick #(
    parameter int HALF_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    output logic tick_o
);

    localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(HALF_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i || (cnt_q == '0)) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/spi_dac_stream_master.sv
// Multi-channel SPI master for AD5681R-class DACs: serialises DATA_W-bit words MSB-first on sclk/mosi, one sync_n per channel.
// Latency: accept to IDLE = 1 + 2*DATA_W*HALF_DIV + 1 + gap cycles; sync_n asserts the cycle after accept.
// Backpressure: in_ready high only in IDLE; in_valid ignored otherwise.
// Ports: clk, rst (async active-high); in_valid/in_ready/in_data/in_ch word handshake;
//        sclk (idles high), mosi, sync_n[NUM_CH] (active-low); busy, frame_done, err_ch status pulses.
// Optional: SPI_DAC_LDAC_PULSE_EN adds ldac_n (low for HALF_DIV cycles at the start of the gap, gap stretched
//           to at least HALF_DIV+1). Without it there is no ldac_n port and the board ties LDAC_n high.
module spi_dac_stream_master
    import spi_dac_pkg::*;
#(
    parameter int DATA_W   = 24,
    parameter int HALF_DIV = 2,
    parameter int NUM_CH   = 1,
    parameter int GAP_CYC  = 2,
    localparam int CH_W    = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CH_W-1:0]   in_ch,
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_CH-1:0] sync_n,
    output logic              busy,
    output logic              frame_done,
    output logic              err_ch
`ifdef SPI_DAC_LDAC_PULSE_EN
    ,
    output logic              ldac_n
`endif
);

`ifdef SPI_DAC_LDAC_PULSE_EN
    // The LDAC pulse lives inside the gap, so the gap must outlast it by one cycle.
    localparam int GAP_LEN = (GAP_CYC > HALF_DIV + 1) ? GAP_CYC : HALF_DIV + 1;
`else
    localparam int GAP_LEN = GAP_CYC;
`endif
    localparam int BW = $clog2(DATA_W);
    localparam int GW = $clog2(GAP_LEN + 1);
    localparam logic [BW-1:0] BIT_TOP  = BW'(DATA_W - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LEN - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              ch_ok_q, ch_ok_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              phase_q, phase_d;   // 0: sclk-high half, 1: sclk-low half
    logic              err_q, err_d;
    logic              tick;
    logic              accept;
    logic              ch_bad;
    logic              framing;

    spi_half_tick #(.HALF_DIV(HALF_DIV)) u_half_tick (
        .clk       (clk),
        .rst       (rst),
        .restart_i (state_q == ST_SETUP),
        .tick_o    (tick)
    );

    assign accept = in_valid && (state_q == ST_IDLE);
    assign ch_bad = (int'(in_ch) >= NUM_CH);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        ch_d    = ch_q;
        ch_ok_d = ch_ok_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        phase_d = phase_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shift_d = in_data;
                    ch_d    = in_ch;
                    ch_ok_d = !ch_bad;
                    err_d   = ch_bad;
                    bit_d   = BIT_TOP;
                    phase_d = 1'b0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (tick) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        // End of the low half: present the next bit as sclk rises.
                        phase_d = 1'b0;
                        shift_d = {shift_q[DATA_W-2:0], 1'b0};
                        bit_d   = bit_q - 1'b1;
                        if (bit_q == '0) begin
                            state_d = ST_HOLD;
                        end
                    end
                end
            end
            ST_HOLD: begin
                gap_d   = '0;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            ch_q    <= '0;
            ch_ok_q <= 1'b0;
            bit_q   <= '0;
            gap_q   <= '0;
            phase_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            ch_q    <= ch_d;
            ch_ok_q <= ch_ok_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            phase_q <= phase_d;
            err_q   <= err_d;
        end
    end

    assign framing    = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);
    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign sclk       = !((state_q == ST_SHIFT) && phase_q);
    assign mosi       = framing && shift_q[DATA_W-1];
    assign frame_done = (state_q == ST_HOLD);
    assign err_ch     = err_q;

    // Out-of-range channels run a dummy frame with every select left high.
    always_comb begin
        sync_n = '1;
        for (int i = 0; i < NUM_CH; i++) begin
            sync_n[i] = !(framing && ch_ok_q && (int'(ch_q) == i));
        end
    end

`ifdef SPI_DAC_LDAC_PULSE_EN
    assign ldac_n = !((state_q == ST_GAP) && (int'(gap_q) < HALF_DIV));
`endif

endmodule

// File: tb/tb_spi_dac_stream_master.sv
module tb_spi_dac_stream_master;

`ifdef SPI_DAC_LDAC_PULSE_EN
    localparam int GAP_2 = 3;   // HALF_DIV=2 builds stretch the gap to HALF_DIV+1
`else
    localparam int GAP_2 = 2;
`endif
    localparam int GAP_1 = 2;   // HALF_DIV=1 build: max(2, 2)

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [23:0] in_data;
    logic [1:0]  in_ch;
    int          sel;

    logic a_rdy, a_sclk, a_mosi, a_busy, a_done, a_err;
    logic b_rdy, b_sclk, b_mosi, b_busy, b_done, b_err;
    logic c_rdy, c_sclk, c_mosi, c_busy, c_done, c_err;
    logic d_rdy, d_sclk, d_mosi, d_busy, d_done, d_err;
    logic [0:0] a_sync;
    logic [3:0] b_sync;
    logic [2:0] c_sync;
    logic [0:0] d_sync;
`ifdef SPI_DAC_LDAC_PULSE_EN
    logic a_ldac, b_ldac, c_ldac, d_ldac;
`endif

    logic       m_rdy, m_sclk, m_mosi, m_busy, m_done, m_err;
    logic [3:0] m_sync;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [23:0] word;
        int          bits;
        int          low;
        logic [3:0]  pat;
    } exp_t;
    exp_t sb[$];

    int done_cnt, done_idx, idle_idx, ldac_cnt, ldac_first, sclk_tog;
    logic low_seen;

    always #10 clk = ~clk;

    spi_dac_stream_master #(.DATA_W(24), .HALF_DIV(2), .NUM_CH(1), .GAP_CYC(2)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel == 0), .in_ready(a_rdy),
        .in_data(in_data), .in_ch(in_ch[0:0]), .sclk(a_sclk), .mosi(a_mosi), .sync_n(a_sync),
        .busy(a_busy), .frame_done(a_done), .err_ch(a_err)
`ifdef SPI_DAC_LDAC_PULSE_EN
        , .ldac_n(a_ldac)
`endif
    );

    spi_dac_stream_master #(.DATA_W(24), .HALF_DIV(2), .NUM_CH(4), .GAP_CYC(2)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel == 1), .in_ready(b_rdy),
        .in_data(in_data), .in_ch(in_ch), .sclk(b_sclk), .mosi(b_mosi), .sync_n(b_sync),
        .busy(b_busy), .frame_done(b_done), .err_ch(b_err)
`ifdef SPI_DAC_LDAC_PULSE_EN
        , .ldac_n(b_ldac)
`endif
    );

    spi_dac_stream_master #(.DATA_W(24), .HALF_DIV(2), .NUM_CH(3), .GAP_CYC(2)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel == 2), .in_ready(c_rdy),
        .in_data(in_data), .in_ch(in_ch), .sclk(c_sclk), .mosi(c_mosi), .sync_n(c_sync),
        .busy(c_busy), .frame_done(c_done), .err_ch(c_err)
`ifdef SPI_DAC_LDAC_PULSE_EN
        , .ldac_n(c_ldac)
`endif
    );

    spi_dac_stream_master #(.DATA_W(16), .HALF_DIV(1), .NUM_CH(1), .GAP_CYC(2)) u_d (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel == 3), .in_ready(d_rdy),
        .in_data(in_data[15:0]), .in_ch(in_ch[0:0]), .sclk(d_sclk), .mosi(d_mosi), .sync_n(d_sync),
        .busy(d_busy), .frame_done(d_done), .err_ch(d_err)
`ifdef SPI_DAC_LDAC_PULSE_EN
        , .ldac_n(d_ldac)
`endif
    );

    // Route the instance under test onto one set of observation signals.
    always_comb begin
        m_rdy = a_rdy; m_sclk = a_sclk; m_mosi = a_mosi; m_busy = a_busy;
        m_done = a_done; m_err = a_err; m_sync = {3'b111, a_sync};
        case (sel)
            1: begin
                m_rdy = b_rdy; m_sclk = b_sclk; m_mosi = b_mosi; m_busy = b_busy;
                m_done = b_done; m_err = b_err; m_sync = b_sync;
            end
            2: begin
                m_rdy = c_rdy; m_sclk = c_sclk; m_mosi = c_mosi; m_busy = c_busy;
                m_done = c_done; m_err = c_err; m_sync = {1'b1, c_sync};
            end
            3: begin
                m_rdy = d_rdy; m_sclk = d_sclk; m_mosi = d_mosi; m_busy = d_busy;
                m_done = d_done; m_err = d_err; m_sync = {3'b111, d_sync};
            end
            default: ;
        endcase
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: rebuild each word from mosi at sclk falling edges while a select is low.
    logic [23:0] cap;
    int          falls, lowc;
    logic [3:0]  pat_seen;
    logic        pat_bad, prev_sclk, prev_low;

    always @(negedge clk) begin
        if (rst) begin
            cap = '0; falls = 0; lowc = 0; pat_bad = 1'b0; prev_sclk = 1'b1; prev_low = 1'b0;
        end else begin
            if (m_sync !== 4'hF) begin
                if (!prev_low) pat_seen = m_sync;
                else if (m_sync !== pat_seen) pat_bad = 1'b1;
                lowc++;
                if (prev_sclk && !m_sclk) begin
                    cap = {cap[22:0], m_mosi};
                    falls++;
                end
            end else if (prev_low) begin
                if (sb.size() == 0) begin
                    chk(32'd1, 32'd0, "sb_unexpected_frame");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk(32'(cap), 32'(e.word), "sb_word");
                    chk(32'(falls), 32'(e.bits), "sb_falling_edges");
                    chk(32'(lowc), 32'(e.low), "sb_sync_low_cycles");
                    chk(32'(pat_seen), 32'(e.pat), "sb_sync_pattern");
                    chk(32'(pat_bad), 32'd0, "sb_sync_stable");
                end
                cap = '0; falls = 0; lowc = 0; pat_bad = 1'b0;
            end
            prev_low  = (m_sync !== 4'hF);
            prev_sclk = m_sclk;
        end
    end

    // Offer a word to instance s; returns at the first negedge after the accept edge (SETUP cycle).
    task automatic send(input logic [23:0] d, input logic [1:0] ch, input int s);
        int n = 0;
        sel = s; in_data = d; in_ch = ch; in_valid = 1'b1;
        while (!m_rdy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(32'(m_rdy), 32'd1, "accept_ready");
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Step through a frame from index 'start' (0 = SETUP) until in_ready returns.
    task automatic run_frame(input int start);
        logic prev;
        done_cnt = 0; done_idx = -1; idle_idx = -1; ldac_cnt = 0; ldac_first = -1;
        sclk_tog = 0; low_seen = 1'b0; prev = m_sclk;
        for (int i = start; i < 400; i++) begin
            if (m_rdy) begin
                idle_idx = i;
                break;
            end
            if (m_done) begin done_cnt++; done_idx = i; end
            if (m_sclk !== prev) sclk_tog++;
            prev = m_sclk;
            if (m_sync !== 4'hF) low_seen = 1'b1;
`ifdef SPI_DAC_LDAC_PULSE_EN
            if (sel == 0 && !a_ldac) begin
                if (ldac_first < 0) ldac_first = i;
                ldac_cnt++;
            end
`endif
            @(negedge clk);
        end
    endtask

    initial begin
        int hi, gap_busy;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ch = '0; sel = 0;
        @(negedge clk);
        @(negedge clk);
        chk(32'(a_rdy), 32'd1, "rst_in_ready");
        chk(32'(a_sclk), 32'd1, "rst_sclk");
        chk(32'(a_mosi), 32'd0, "rst_mosi");
        chk(32'(a_sync), 32'd1, "rst_sync_n");
        chk(32'(a_busy), 32'd0, "rst_busy");
        chk(32'(a_done), 32'd0, "rst_frame_done");
        chk(32'(a_err), 32'd0, "rst_err_ch");
        rst = 1'b0;
        @(negedge clk);

        // Single default frame.
        sb.push_back('{24'h300000, 24, 98, 4'hE});
        send(24'h300000, 2'd0, 0);
        chk(32'(m_sync), 32'hE, "t1_setup_sync");
        chk(32'(m_mosi), 32'd0, "t1_setup_mosi");
        chk(32'(m_busy), 32'd1, "t1_setup_busy");
        chk(32'(m_rdy), 32'd0, "t1_setup_ready");
        run_frame(0);
        chk(32'(done_cnt), 32'd1, "t1_done_count");
        chk(32'(done_idx), 32'd97, "t1_done_index");
        chk(32'(idle_idx), 32'(98 + GAP_2), "t1_ready_index");
`ifdef SPI_DAC_LDAC_PULSE_EN
        chk(32'(ldac_cnt), 32'd2, "t6_ldac_len");
        chk(32'(ldac_first), 32'(done_idx + 1), "t6_ldac_start");
`endif

        // Four channels, back-to-back with in_valid held.
        sb.push_back('{24'h340000, 24, 98, 4'hB});
        sb.push_back('{24'h3FFF00, 24, 98, 4'hE});
        send(24'h340000, 2'd2, 1);
        chk(32'(m_sync), 32'hB, "t2_first_sync");
        in_data = 24'h3FFF00; in_ch = 2'd0; in_valid = 1'b1;
        hi = 0; gap_busy = 0;
        for (int i = 0; i < 400; i++) begin
            if (m_sync === 4'hE) break;
            if (m_sync === 4'hF) begin
                hi++;
                if (m_busy) gap_busy++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk(32'(m_sync), 32'hE, "t2_second_sync");
        chk(32'(gap_busy), 32'(GAP_2), "t2_gap_cycles");
        chk(32'(hi), 32'(GAP_2 + 1), "t2_sync_high_cycles");
        run_frame(0);
        chk(32'(idle_idx), 32'(98 + GAP_2), "t2_ready_index");

        // Out-of-range channel runs a dummy frame.
        send(24'h123456, 2'd3, 2);
        chk(32'(m_err), 32'd1, "t3_err_pulse");
        chk(32'(m_sync), 32'hF, "t3_setup_sync");
        @(negedge clk);
        chk(32'(m_err), 32'd0, "t3_err_single");
        run_frame(1);
        chk(32'(low_seen), 32'd0, "t3_sync_never_low");
        chk(32'(done_cnt), 32'd1, "t3_done_count");
        chk(32'(done_idx), 32'd97, "t3_done_index");
        chk(32'(idle_idx), 32'(98 + GAP_2), "t3_ready_index");

        // Reset during bit 10 of a frame, then a clean frame.
        send(24'h3ABCDE, 2'd0, 0);
        repeat (54) @(negedge clk);
        chk(32'(m_mosi), 32'd1, "t4_pre_mosi");
        chk(32'(m_sync), 32'hE, "t4_pre_sync");
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk(32'(a_sync), 32'd1, "t4_rst_sync");
        chk(32'(a_sclk), 32'd1, "t4_rst_sclk");
        chk(32'(a_mosi), 32'd0, "t4_rst_mosi");
        chk(32'(a_rdy), 32'd1, "t4_rst_ready");
        chk(32'(a_busy), 32'd0, "t4_rst_busy");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sb.push_back('{24'h38FF00, 24, 98, 4'hE});
        send(24'h38FF00, 2'd0, 0);
        run_frame(0);
        chk(32'(idle_idx), 32'(98 + GAP_2), "t4_ready_index");

        // Fastest clock ratio with a 16-bit frame.
        sb.push_back('{24'h00A5C3, 16, 34, 4'hE});
        send(24'h00A5C3, 2'd0, 3);
        run_frame(0);
        chk(32'(sclk_tog), 32'd32, "t5_sclk_toggles");
        chk(32'(done_idx), 32'd33, "t5_done_index");
        chk(32'(idle_idx), 32'(34 + GAP_1), "t5_ready_index");

        repeat (3) @(negedge clk);
        chk(32'(sb.size()), 32'd0, "sb_leftover");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
